ts4231_pulse_capture: RTL
=========================

// Module: ts4231_pulse_capture
// PURPOSE
// - Downstream of the TS4231 configurator. Once `configured` is high, watches the sensor
//   envelope line E (active-low: low = light present).
// - Per light pulse, captures start timestamp and width in clk cycles (96 MHz).
// - Rejects glitches; queues records in a small first-word-fall-through FIFO with a
//   valid/ready handshake for the lighthouse decoding logic.
// PARAMETERS
// - TS_WIDTH    32  width of free-running timestamp counter (wraps modulo 2^TS_WIDTH)
// - W_WIDTH     16  width of pulse-width field; saturates at 2^W_WIDTH-1
// - FIFO_DEPTH  4   record FIFO depth; power of 2, >=2
// - MIN_PULSE   8   pulses shorter than this many cycles are discarded as glitches
// PORTS
// - clk            in   1         system clock, 96 MHz
// - rst            in   1         asynchronous, active-high reset
// - enable         in   1         connect to configurator `configured`; capture only while high
// - e_in           in   1         raw TS4231 E pin (async to clk)
// - pulse_valid    out  1         FIFO non-empty; head record on pulse_* outputs
// - pulse_ready    in   1         consumer accepts head record when valid && ready
// - pulse_start    out  TS_WIDTH  timestamp of first synchronised low sample
// - pulse_width    out  W_WIDTH   low duration in clk cycles (saturated)
// - overflow       out  1         sticky: a valid pulse was dropped because FIFO full
// - overflow_clr   in   1         synchronous clear of overflow (clear wins over a same-cycle set)
// BEHAVIOUR
// - Reset values
//   - Outputs: pulse_valid=0, pulse_start=0, pulse_width=0, overflow=0.
//   - Internal: FIFO empty, ts=0, state=IDLE, synchroniser flops=1.
// - Synchroniser: e_in passes 2 flops (e_s). All timing uses e_s.
//   - Constant +2 cycle offset on pulse_start; not compensated.
// - Timestamp ts: increments every clk from reset, independent of enable, wraps silently.
// - FSM:
//   - IDLE: enable=1 -> WAIT_HIGH.
//   - WAIT_HIGH: e_s=1 -> ARMED. Never captures a pulse already in progress at enable.
//   - ARMED: e_s=0 -> IN_PULSE; latch start=ts, width=1.
//   - IN_PULSE:
//     - While e_s=0: width+1, saturating at all-ones.
//     - e_s=1 with width<MIN_PULSE: discard, -> ARMED.
//     - e_s=1 with width>=MIN_PULSE: push request this cycle, -> ARMED.
//     - Record visible on pulse_valid 1 cycle after the rising edge.
//   - enable=0 in any state: -> IDLE next cycle; partial pulse discarded; FIFO contents kept.
// - Push/pop rules:
//   - Push accepted if count<FIFO_DEPTH, or if a pop happens the same cycle (full-with-pop
//     keeps count at DEPTH).
//   - Otherwise the record is dropped and overflow is set.
//   - Pop on pulse_valid && pulse_ready.
//   - Head outputs stable while valid && !ready.
//   - Pop on empty has no effect.
// - Back-to-back pulses: after a push, the next falling edge may be captured the very next
//   cycle (ARMED is 1 cycle minimum).
// - Wrap: pulse_start may exceed the next record's start across ts wrap; consumer handles
//   modulo arithmetic.
// CONFIGURATION
// - TS4231_PULSE_CLASSIFY_EN defined:
//   - Adds parameters SYNC_MIN (default 5000) and SYNC_MAX (default 13440).
//   - Adds output port pulse_kind [1:0], stored per record in the FIFO:
//     - 0 = sweep (width<SYNC_MIN)
//     - 1 = sync (SYNC_MIN..SYNC_MAX inclusive)
//     - 2 = long (>SYNC_MAX or saturated)
//   - Reset value 0.
// - Macro undefined: no pulse_kind port, no classifier logic; FIFO word = start+width only.
// TESTING
// - After enable=1, E high; E low 1000 cycles -> one record: width=1000,
//   pulse_start = ts at low sample (+2 sync offset), pulse_valid 1 cycle after release.
// - E low 5 cycles (MIN_PULSE=8) -> no record. E low exactly 8 cycles -> record, width=8.
// - E held low before enable rises, released after 300 cycles -> no record; next 50-cycle
//   pulse -> record width=50.
// - pulse_ready=0, 5 valid pulses (DEPTH=4) -> 4 records, overflow=1, first four retained in
//   order. Overflow_clr -> 0. Full FIFO with pop and push in the same cycle -> count stays 4,
//   no overflow.
// - enable drops mid-pulse -> no record; rst asserted mid-pulse -> all outputs 0 immediately.
// - With TS4231_PULSE_CLASSIFY_EN: widths 960 / 6000 / 20000 -> pulse_kind 0 / 1 / 2;
//   E low 70000 cycles -> width=65535, kind=2.

Source files
------------

// File: rtl/ts4231_pulse_capture.sv
// Purpose: time-stamp and measure TS4231 envelope (E, active-low) light pulses, queue {start,width[,kind]} records.
// Latency: record valid 1 cycle after the synchronised rising edge of E (3 clk after the raw pin rises).
// Backpressure: valid/ready FWFT FIFO; a full FIFO with no same-cycle pop drops the record and sets sticky overflow.
// Optional build macro TS4231_PULSE_CLASSIFY_EN adds a per-record pulse_kind (sweep/sync/long) output.
module ts4231_pulse_capture #(
    parameter int TS_WIDTH   = 32,
    parameter int W_WIDTH    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_PULSE  = 8
`ifdef TS4231_PULSE_CLASSIFY_EN
    ,
    parameter int SYNC_MIN   = 5000,
    parameter int SYNC_MAX   = 13440
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                e_in,
    output logic                pulse_valid,
    input  logic                pulse_ready,
    output logic [TS_WIDTH-1:0] pulse_start,
    output logic [W_WIDTH-1:0]  pulse_width,
    output logic                overflow,
    input  logic                overflow_clr
`ifdef TS4231_PULSE_CLASSIFY_EN
    ,
    output logic [1:0]          pulse_kind
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [W_WIDTH-1:0] W_MAX = '1;
    localparam logic [W_WIDTH-1:0] MIN_W = W_WIDTH'(MIN_PULSE);
    localparam logic [CW-1:0]      DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [TS_WIDTH-1:0] start;
        logic [W_WIDTH-1:0]  width;
`ifdef TS4231_PULSE_CLASSIFY_EN
        logic [1:0]          kind;
`endif
    } rec_t;

    typedef enum logic [1:0] {IDLE, WAIT_HIGH, ARMED, IN_PULSE} state_t;

    state_t              state, state_nxt;
    logic                e_meta, e_s;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] cur_start;
    logic [W_WIDTH-1:0]  cur_width;
    logic                load_pulse, inc_width, push_req, push_ok, pop, full;
    rec_t                push_rec, head;
    rec_t                mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;

    // Two-flop synchroniser for the asynchronous E pin; idles high (no light).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_meta <= 1'b1;
            e_s    <= 1'b1;
        end else begin
            e_meta <= e_in;
            e_s    <= e_meta;
        end
    end

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and pulse-event decode; losing enable aborts any partial pulse.
    always_comb begin
        state_nxt  = state;
        load_pulse = 1'b0;
        inc_width  = 1'b0;
        push_req   = 1'b0;
        case (state)
            IDLE:      if (enable) state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (e_s) state_nxt = ARMED;
            ARMED: begin
                if (!e_s) begin
                    load_pulse = 1'b1;
                    state_nxt  = IN_PULSE;
                end
            end
            IN_PULSE: begin
                if (!e_s) begin
                    inc_width = 1'b1;
                end else begin
                    push_req  = (cur_width >= MIN_W);
                    state_nxt = ARMED;
                end
            end
            default:   state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt  = IDLE;
            load_pulse = 1'b0;
            inc_width  = 1'b0;
            push_req   = 1'b0;
        end
    end

    // Start timestamp latch and saturating width counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_start <= '0;
            cur_width <= '0;
        end else if (load_pulse) begin
            cur_start <= ts;
            cur_width <= W_WIDTH'(1);
        end else if (inc_width && (cur_width != W_MAX)) begin
            cur_width <= cur_width + 1'b1;
        end
    end

    // Record assembly, including optional classification of the finished width.
    always_comb begin
        push_rec       = '0;
        push_rec.start = cur_start;
        push_rec.width = cur_width;
`ifdef TS4231_PULSE_CLASSIFY_EN
        if ((cur_width == W_MAX) || (32'(cur_width) > 32'(SYNC_MAX)))
            push_rec.kind = 2'd2;
        else if (32'(cur_width) >= 32'(SYNC_MIN))
            push_rec.kind = 2'd1;
        else
            push_rec.kind = 2'd0;
`endif
    end

    assign full        = (count == DEPTH_C);
    assign pulse_valid = (count != '0);
    assign pop         = pulse_valid && pulse_ready;
    assign push_ok     = push_req && (!full || pop);
    assign head        = mem[rd_ptr];

    // Head record presented only while valid so an empty FIFO shows zeros.
    assign pulse_start = pulse_valid ? head.start : '0;
    assign pulse_width = pulse_valid ? head.width : '0;
`ifdef TS4231_PULSE_CLASSIFY_EN
    assign pulse_kind  = pulse_valid ? head.kind : 2'd0;
`endif

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_rec;
    end

    // FIFO pointers and occupancy; a pop and push on a full FIFO keep it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow on a dropped record; clear has priority over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      overflow <= 1'b0;
        else if (overflow_clr)        overflow <= 1'b0;
        else if (push_req && !push_ok) overflow <= 1'b1;
    end

endmodule
